// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: M-extension funct3 codes, mul/div FSM states
// and the default datapath width.
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE   = 2'd0,
    MD_CALC   = 2'd1,
    MD_FINISH = 2'd2
  } md_state_e;

  function automatic logic md_is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  // rs1 is treated as signed by MULH, MULHSU, DIV and REM
  function automatic logic md_a_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3[2] && !f3[0]);
  endfunction

  function automatic logic md_b_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3[2] && !f3[0]);
  endfunction

endpackage

// File: rtl/riscv_muldiv_if.sv
// Issue/result handshake between the EXECUTE stage and the mul/div unit.
interface riscv_muldiv_if #(
  parameter int XLEN = riscv_pkg::XLEN_DEFAULT
) ();
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, funct3, rs1, rs2, input busy, done, result);
  modport slave  (input start, funct3, rs1, rs2, output busy, done, result);
endinterface

// File: rtl/riscv_muldiv_divu_step.sv
// One restoring-division iteration on unsigned magnitudes: shift
// remainder||quotient left and subtract the divisor when it fits.
module seq_divu_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] div_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;

  assign shifted = {rem_i, quo_i[XLEN-1]};
  // The running remainder stays below the divisor, so the difference fits XLEN bits
  assign diff    = shifted[XLEN-1:0] - div_i;

  always_comb begin
    if (shifted >= {1'b0, div_i}) begin
      rem_o = diff;
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end else begin
      rem_o = shifted[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/riscv_muldiv.sv
// Sequential RV32M/RV64M multiply-divide unit: operands are reduced to
// magnitudes on issue, iterated in a shared accumulator, sign-fixed on finish.
module riscv_muldiv
  import riscv_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter bit FAST_MUL = 1'b1
) (
  input logic          clk,
  input logic          reset,
  riscv_muldiv_if.slave bus
);

  localparam int              CW       = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [XLEN-1:0]   opa_q, opa_d, opb_q, opb_d, result_q, result_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              neg_q, neg_d, spec_q, spec_d, done_q, done_d;
  logic              busy;

  logic              is_div, a_neg, b_neg, div_zero, div_ovf, special, fast_path;
  logic [XLEN-1:0]   a_mag, b_mag, spec_val;

  assign is_div    = md_is_div(bus.funct3);
  assign a_neg     = md_a_signed(bus.funct3) & bus.rs1[XLEN-1];
  assign b_neg     = md_b_signed(bus.funct3) & bus.rs2[XLEN-1];
  assign a_mag     = a_neg ? -bus.rs1 : bus.rs1;
  assign b_mag     = b_neg ? -bus.rs2 : bus.rs2;
  assign div_zero  = is_div && (bus.rs2 == {XLEN{1'b0}});
  assign div_ovf   = is_div && !bus.funct3[0] && (bus.rs1 == MIN_NEG) && (bus.rs2 == {XLEN{1'b1}});
  assign special   = div_zero | div_ovf;
  assign fast_path = special | (FAST_MUL & !is_div);
  assign spec_val  = div_zero ? (bus.funct3[1] ? bus.rs1 : {XLEN{1'b1}})
                              : (bus.funct3[1] ? {XLEN{1'b0}} : bus.rs1);

  logic [XLEN-1:0]   step_rem, step_quo;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, fast_prod, prod, prod_c;
  logic [XLEN-1:0]   quo_c, rem_c, fin_val;

  seq_divu_step #(.XLEN(XLEN)) u_step (
    .rem_i (acc_q[2*XLEN-1:XLEN]),
    .quo_i (acc_q[XLEN-1:0]),
    .div_i (opb_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // Shift-add multiply: accumulator holds {partial product, remaining multiplier bits}
  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opa_q} : {(XLEN+1){1'b0}});
  assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
  assign fast_prod = {{XLEN{1'b0}}, opa_q} * {{XLEN{1'b0}}, opb_q};
  assign prod      = FAST_MUL ? fast_prod : acc_q;
  assign prod_c    = neg_q ? -prod : prod;
  assign quo_c     = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_c     = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    fin_val = {XLEN{1'b0}};
    if (spec_q) begin
      fin_val = acc_q[XLEN-1:0];
    end else begin
      case (f3_q)
        F3_MUL:                      fin_val = prod_c[XLEN-1:0];
        F3_MULH, F3_MULHSU, F3_MULHU: fin_val = prod_c[2*XLEN-1:XLEN];
        F3_DIV, F3_DIVU:             fin_val = quo_c;
        F3_REM, F3_REMU:             fin_val = rem_c;
        default:                     fin_val = {XLEN{1'b0}};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= MD_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE:   state_d = bus.start ? (fast_path ? MD_FINISH : MD_CALC) : MD_IDLE;
      MD_CALC:   state_d = (cnt_q == CNT_LAST) ? MD_FINISH : MD_CALC;
      MD_FINISH: state_d = MD_IDLE;
      default:   state_d = MD_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != MD_IDLE);
  end

  assign bus.busy   = busy;
  assign bus.done   = done_q;
  assign bus.result = result_q;

  always_comb begin
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    spec_d   = spec_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (bus.start) begin
          cnt_d  = {CW{1'b0}};
          f3_d   = bus.funct3;
          opa_d  = a_mag;
          opb_d  = b_mag;
          spec_d = special;
          // Remainder takes the dividend's sign; everything else the XOR of signs
          neg_d  = (is_div && bus.funct3[1]) ? a_neg : (a_neg ^ b_neg);
          if (special)     acc_d = {{XLEN{1'b0}}, spec_val};
          else if (is_div) acc_d = {{XLEN{1'b0}}, a_mag};
          else             acc_d = {{XLEN{1'b0}}, b_mag};
        end else begin
          cnt_d = cnt_q;
        end
      end
      MD_CALC: begin
        acc_d = f3_q[2] ? {step_rem, step_quo} : mul_next;
        cnt_d = (cnt_q == CNT_LAST) ? {CW{1'b0}} : cnt_q + 1'b1;
      end
      MD_FINISH: begin
        result_d = fin_val;
        done_d   = 1'b1;
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= {CW{1'b0}};
      f3_q     <= 3'b000;
      opa_q    <= {XLEN{1'b0}};
      opb_q    <= {XLEN{1'b0}};
      acc_q    <= {(2*XLEN){1'b0}};
      neg_q    <= 1'b0;
      spec_q   <= 1'b0;
      result_q <= {XLEN{1'b0}};
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      spec_q   <= spec_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_riscv_muldiv.sv
// Directed bench: one unit with single-cycle multiply, one fully iterative,
// sharing clock, reset and a stimulus bus steered by sel.
module tb_riscv_muldiv;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] rs1 = 32'h0, rs2 = 32'h0;
  logic        busy, done;
  logic [31:0] result;
  int          nchk = 0;
  int          nerr = 0;

  always #5 clk = ~clk;

  riscv_muldiv_if #(.XLEN(32)) f_if ();
  riscv_muldiv_if #(.XLEN(32)) s_if ();

  assign f_if.start  = start & ~sel;
  assign s_if.start  = start & sel;
  assign f_if.funct3 = funct3;
  assign s_if.funct3 = funct3;
  assign f_if.rs1    = rs1;
  assign s_if.rs1    = rs1;
  assign f_if.rs2    = rs2;
  assign s_if.rs2    = rs2;
  assign busy   = sel ? s_if.busy   : f_if.busy;
  assign done   = sel ? s_if.done   : f_if.done;
  assign result = sel ? s_if.result : f_if.result;

  riscv_muldiv #(.XLEN(32), .FAST_MUL(1'b1)) u_fast (.clk(clk), .reset(reset), .bus(f_if));
  riscv_muldiv #(.XLEN(32), .FAST_MUL(1'b0)) u_slow (.clk(clk), .reset(reset), .bus(s_if));

  // Issue one op; latency counts the accepting edge as 1; busy_bad counts busy/done overlaps or gaps
  task automatic run_op(input logic s, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int busy_bad);
    bit got;
    @(negedge clk);
    sel = s; funct3 = f3; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 1; busy_bad = 0; res = 32'hxxxxxxxx; got = 1'b0;
    if (busy !== 1'b1) busy_bad++;
    while (!got && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (done === 1'b1) begin
        got = 1'b1;
        res = result;
        if (busy !== 1'b0) busy_bad++;
      end else if (busy !== 1'b1) begin
        busy_bad++;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    nchk++;
    if ({f_if.busy, f_if.done, s_if.busy, s_if.done} !== 4'b0000) begin
      nerr++; $display("FAIL reset_flags: got %b expected 0000", {f_if.busy, f_if.done, s_if.busy, s_if.done});
    end
    nchk++;
    if (f_if.result !== 32'h0 || s_if.result !== 32'h0) begin
      nerr++; $display("FAIL reset_result: got %h/%h expected 0", f_if.result, s_if.result);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Same multiply vectors on both units: latency 2 when fast, 34 when iterative
  task automatic test_mul(input logic s, input int exp_lat);
    logic [2:0]  f3s [4];
    logic [31:0] as  [4];
    logic [31:0] bs  [4];
    logic [31:0] exps[4];
    logic [31:0] res;
    int lat, bb;
    f3s  = '{F3_MUL, F3_MULH, F3_MULHU, F3_MULHSU};
    as   = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFFF};
    bs   = '{32'h00000003, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFF};
    exps = '{32'hFFFFFFEB, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF};
    for (int i = 0; i < 4; i++) begin
      run_op(s, f3s[i], as[i], bs[i], res, lat, bb);
      nchk++;
      if (res !== exps[i]) begin
        nerr++; $display("FAIL mul_result[%0d] f3=%0d: got %h expected %h", s, f3s[i], res, exps[i]);
      end
      nchk++;
      if (lat !== exp_lat || bb !== 0) begin
        nerr++; $display("FAIL mul_latency[%0d] f3=%0d: got lat %0d busy_bad %0d expected lat %0d busy_bad 0", s, f3s[i], lat, bb, exp_lat);
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  f3s [4];
    logic [31:0] as  [4];
    logic [31:0] bs  [4];
    logic [31:0] exps[4];
    logic [31:0] res;
    int lat, bb;
    f3s  = '{F3_DIV, F3_REM, F3_DIVU, F3_REMU};
    as   = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
    bs   = '{32'h00000002, 32'h00000002, 32'd7, 32'd7};
    exps = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
    for (int i = 0; i < 4; i++) begin
      run_op(i[0], f3s[i], as[i], bs[i], res, lat, bb);
      nchk++;
      if (res !== exps[i]) begin
        nerr++; $display("FAIL div_result f3=%0d: got %h expected %h", f3s[i], res, exps[i]);
      end
      nchk++;
      if (lat !== 34 || bb !== 0) begin
        nerr++; $display("FAIL div_latency f3=%0d: got lat %0d busy_bad %0d expected lat 34 busy_bad 0", f3s[i], lat, bb);
      end
    end
  endtask

  task automatic test_special();
    logic [2:0]  f3s [5];
    logic [31:0] as  [5];
    logic [31:0] bs  [5];
    logic [31:0] exps[5];
    logic [31:0] res;
    int lat, bb;
    f3s  = '{F3_DIV, F3_REM, F3_DIV, F3_REM, F3_DIVU};
    as   = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'd5};
    bs   = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
    exps = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'hFFFFFFFF};
    for (int i = 0; i < 5; i++) begin
      run_op(i == 4, f3s[i], as[i], bs[i], res, lat, bb);
      nchk++;
      if (res !== exps[i]) begin
        nerr++; $display("FAIL special_result[%0d]: got %h expected %h", i, res, exps[i]);
      end
      nchk++;
      if (lat !== 2 || bb !== 0) begin
        nerr++; $display("FAIL special_latency[%0d]: got lat %0d busy_bad %0d expected lat 2 busy_bad 0", i, lat, bb);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int lat;
    bit got;
    logic [31:0] res;
    @(negedge clk);
    sel = 1'b0; funct3 = F3_DIVU; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 1; got = 1'b0; res = 32'hxxxxxxxx;
    repeat (4) begin @(posedge clk); lat++; end
    @(negedge clk);
    funct3 = F3_REMU; rs1 = 32'd55; rs2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    lat++; start = 1'b0;
    while (!got && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (done === 1'b1) begin got = 1'b1; res = result; end
    end
    nchk++;
    if (res !== 32'd14) begin
      nerr++; $display("FAIL ignore_start_result: got %h expected %h", res, 32'd14);
    end
    nchk++;
    if (lat !== 34) begin
      nerr++; $display("FAIL ignore_start_latency: got %0d expected 34", lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    int lat, bb;
    run_op(1'b1, F3_DIVU, 32'd100, 32'd7, res, lat, bb);
    nchk++;
    if (res !== 32'd14) begin
      nerr++; $display("FAIL b2b_first: got %h expected %h", res, 32'd14);
    end
    // run_op drives start in the done cycle of the previous op
    run_op(1'b1, F3_DIV, 32'hFFFFFFF9, 32'd2, res, lat, bb);
    nchk++;
    if (res !== 32'hFFFFFFFD || lat !== 34 || bb !== 0) begin
      nerr++; $display("FAIL b2b_second: got %h lat %0d busy_bad %0d expected FFFFFFFD lat 34 busy_bad 0", res, lat, bb);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int lat, bb, spurious;
    @(negedge clk);
    sel = 1'b1; funct3 = F3_DIV; rs1 = 32'hFFFFFFF9; rs2 = 32'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    nchk++;
    if ({s_if.busy, s_if.done} !== 2'b00 || s_if.result !== 32'h0) begin
      nerr++; $display("FAIL reset_mid_state: got busy/done %b result %h expected 00 / 0", {s_if.busy, s_if.done}, s_if.result);
    end
    @(negedge clk);
    reset = 1'b0;
    spurious = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (s_if.done === 1'b1 || s_if.busy === 1'b1) spurious++;
    end
    nchk++;
    if (spurious !== 0) begin
      nerr++; $display("FAIL reset_mid_no_done: got %0d active cycles expected 0", spurious);
    end
    run_op(1'b1, F3_DIVU, 32'd100, 32'd7, res, lat, bb);
    nchk++;
    if (res !== 32'd14 || lat !== 34) begin
      nerr++; $display("FAIL reset_mid_next_op: got %h lat %0d expected %h lat 34", res, lat, 32'd14);
    end
  endtask

  initial begin
    test_reset();
    test_mul(1'b0, 2);
    test_mul(1'b1, 34);
    test_div();
    test_special();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/riscv_muldiv.md
# riscv_muldiv

Parametrised sequential RV32M/RV64M multiply-divide unit for the multi-cycle RISC-V core. Replaces the core's combinational MUL/MULH path and adds MULHSU, MULHU, DIV, DIVU, REM and REMU. The EXECUTE stage issues one operation with a start pulse, stalls while busy is high, and writes back on the one-cycle done pulse. Iterative shift-subtract division, with optional single-cycle multiply.

## Interface
- XLEN, 32: operand/result width; 32 or 64.
- FAST_MUL, 1: 1 = multiply resolved in the FINISH path (`*` operator); 0 = iterative shift-add, one bit per cycle.

- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  issue request; sampled only while busy=0.
- funct3  in  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1  in  XLEN  operand A (dividend / multiplicand).
- rs2  in  XLEN  operand B (divisor / multiplier).
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse; result valid in that cycle only.
- result  out  XLEN  operation result; holds its value until the next done.

## Operation
- States: IDLE, CALC, FINISH.
  - busy = (state != IDLE).
  - done is a registered output.
- IDLE, start=1 at edge k:
  - latch funct3 and operand magnitudes (|x| for signed operands per op), result sign, and special-case flags.
  - cnt <= 0.
  - next state FINISH if the op is a special case or (FAST_MUL and multiply); otherwise CALC.
- CALC: one iteration per edge.
  - Division: restoring; shift remainder||quotient left 1, subtract divisor when the remainder is ≥ divisor.
  - Multiply: 2·XLEN-bit accumulator; add the multiplicand when the multiplier LSB is 1, then shift.
  - At cnt = XLEN-1: cnt <= 0, state <= FINISH.
- FINISH:
  - apply two's-complement sign correction and select lo/hi, quotient or remainder into result.
  - done <= 1, state <= IDLE.
- Sign rules:
  - MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - DIV/REM: quotient negative iff signs differ; remainder takes the dividend's sign.
  - MUL and the unsigned ops take no correction.
- Special cases, resolved without CALC:
  - divisor = 0: DIV/DIVU → all ones; REM/REMU → rs1.
  - DIV/REM with rs1 = 1 followed by XLEN-1 zeros and rs2 = all ones: DIV → rs1, REM → 0.
- start while busy=1: ignored, with no effect on the in-flight op. The requester must hold start until it sees busy=0.
- start in the same cycle as done=1: accepted, because state is already IDLE.
- reset at any edge:
  - state IDLE, busy 0, done 0, result 0, cnt 0.
  - any in-flight op is abandoned with no done.

## Timing
- start accepted at edge k.
- Iterative path: FINISH at edge k+XLEN; done=1 in the cycle after edge k+XLEN+1. Latency is XLEN+2 edges (34 for XLEN=32).
- Fast path (special case, or FAST_MUL multiply): done=1 after edge k+1. Latency is 2 edges.
- busy=1 from after edge k until after the edge that raises done. busy and done are never high together.
- result is combinationally stable during done and registered. It stays unchanged while the next op computes.
- Throughput: one op per XLEN+2 cycles, back-to-back with no bubble.

## Structure
- Shared package riscv_pkg:
  - funct3 localparams: F3_MUL … F3_REMU.
  - state encoding: MD_IDLE, MD_CALC, MD_FINISH.
  - the XLEN default.
  - The core decoder already consumes this package.
- Sub-module seq_divu_step: combinational single restoring-division step, parametrised by XLEN. The iterative multiply shares the same accumulator register in the top.
- cnt width: $clog2(XLEN).

## Test plan
- MUL/MULH, rs1 = 0xFFFFFFF9, rs2 = 3, FAST_MUL=1 → 0xFFFFFFEB / 0xFFFFFFFF. done exactly 2 edges after start.
- MULHU 0xFFFFFFFF·0xFFFFFFFF → 0xFFFFFFFE. MULHSU with the same operands → 0xFFFFFFFF. Repeat with FAST_MUL=0: done after 34 edges, same values.
- DIV/REM, −7/2 → 0xFFFFFFFD / 0xFFFFFFFF. DIVU/REMU, 100/7 → 14 / 2. Each has latency 34 with busy high throughout.
- Divisor 0: DIV 5/0 → 0xFFFFFFFF, REM → 5. Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, REM → 0. Both with latency 2.
- start pulsed during busy with a different funct3 → ignored, first result correct. A new start on the done cycle is accepted and its done follows 34 edges later.
- reset asserted mid-CALC (edge k+10) → busy and done go to 0 next cycle, no done appears, and the next op computes correctly.
